// File: rtl/x_alp_exit_monitor.sv
// x_alp_exit_monitor: folds per-channel exit requests into one exit report,
// with first-exit or wait-for-all completion and a programmable watchdog.
module x_alp_exit_monitor #(
  parameter int unsigned        NUM_CH       = 4,
  parameter int unsigned        VALUE_W      = 32,
  parameter int unsigned        TIMEOUT_W    = 32,
  parameter bit                 WAIT_ALL     = 1'b0,
  parameter logic [VALUE_W-1:0] TIMEOUT_CODE = {VALUE_W{1'b1}},
  parameter int unsigned        SRC_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic [TIMEOUT_W-1:0]      timeout_cycles_i,
  input  logic [NUM_CH-1:0]         ch_exit_valid_i,
  input  logic [NUM_CH*VALUE_W-1:0] ch_exit_value_i,
  output logic                      exit_valid_o,
  output logic [VALUE_W-1:0]        exit_value_o,
  output logic [SRC_W-1:0]          exit_src_o,
  output logic                      timeout_o,
  output logic [NUM_CH-1:0]         done_mask_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [TIMEOUT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_CH-1:0]              mask_q, mask_d;
  logic [NUM_CH-1:0][VALUE_W-1:0] cap_q, cap_d;
  logic                           exit_valid_q, exit_valid_d;
  logic [VALUE_W-1:0]             exit_value_q, exit_value_d;
  logic [SRC_W-1:0]               exit_src_q, exit_src_d;
  logic                           timeout_q, timeout_d;

  logic [NUM_CH-1:0]              new_cap_c;
  logic [NUM_CH-1:0]              mask_upd_c;
  logic [NUM_CH-1:0][VALUE_W-1:0] cap_upd_c;
  logic                           sel_found_c;
  logic [SRC_W-1:0]               sel_idx_c;
  logic [VALUE_W-1:0]             sel_val_c;
  logic                           complete_c;
  logic                           tmo_hit_c;

  // This cycle's captures, the completion condition and the reported channel
  always_comb begin
    new_cap_c   = ch_exit_valid_i & ~mask_q;
    mask_upd_c  = mask_q | new_cap_c;
    cap_upd_c   = cap_q;
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    sel_val_c   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (new_cap_c[i]) begin
        cap_upd_c[i] = ch_exit_value_i[i*VALUE_W +: VALUE_W];
      end
    end
    // First-exit reports the lowest new capture; wait-all the lowest non-zero code
    for (int i = 0; i < NUM_CH; i++) begin
      if (!sel_found_c && (WAIT_ALL ? (cap_upd_c[i] != '0) : new_cap_c[i])) begin
        sel_found_c = 1'b1;
        sel_idx_c   = SRC_W'(i);
        sel_val_c   = cap_upd_c[i];
      end
    end
    complete_c = WAIT_ALL ? (&mask_upd_c) : (|new_cap_c);
    // >= rather than == so that a limit lowered mid-run still fires
    tmo_hit_c  = (timeout_cycles_i != '0) &&
                 (cnt_q >= (timeout_cycles_i - TIMEOUT_W'(1))) &&
                 !complete_c;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    cap_d        = cap_q;
    exit_valid_d = exit_valid_q;
    exit_value_d = exit_value_q;
    exit_src_d   = exit_src_q;
    timeout_d    = timeout_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        mask_d = '0;
        cap_d  = '0;
        if (enable_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_i || !enable_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          mask_d  = '0;
          cap_d   = '0;
        end else begin
          mask_d = mask_upd_c;
          cap_d  = cap_upd_c;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
          end
          if (complete_c) begin
            state_d      = ST_DONE;
            exit_valid_d = 1'b1;
            exit_value_d = sel_val_c;
            exit_src_d   = sel_idx_c;
            timeout_d    = 1'b0;
          end else if (tmo_hit_c) begin
            state_d      = ST_DONE;
            exit_valid_d = 1'b1;
            exit_value_d = TIMEOUT_CODE;
            exit_src_d   = '0;
            timeout_d    = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (clear_i) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          mask_d       = '0;
          cap_d        = '0;
          exit_valid_d = 1'b0;
          exit_value_d = '0;
          exit_src_d   = '0;
          timeout_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      cap_q        <= '0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
      exit_src_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      cap_q        <= cap_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
      exit_src_q   <= exit_src_d;
      timeout_q    <= timeout_d;
    end
  end

  assign exit_valid_o = exit_valid_q;
  assign exit_value_o = exit_value_q;
  assign exit_src_o   = exit_src_q;
  assign timeout_o    = timeout_q;
  assign done_mask_o  = mask_q;

endmodule

// File: tb/tb_x_alp_exit_monitor.sv
// Bench for x_alp_exit_monitor: one first-exit and one wait-all instance share
// stimulus; both are compared every cycle against a behavioural model.
module tb_x_alp_exit_monitor;

  logic         clk;
  logic         rst;
  logic         en;
  logic         clr;
  logic [31:0]  tmo;
  logic [3:0]   sv;
  logic [127:0] svals;

  logic         ev    [2];
  logic [31:0]  evl   [2];
  logic [1:0]   esrc  [2];
  logic         eto   [2];
  logic [3:0]   emask [2];

  int n_chk;
  int n_pass;

  // Model: run phase per instance (0 idle, 1 run, 2 done) and the reported exit
  int          m_st   [2];
  longint      m_cyc  [2];
  bit          m_mask [2][4];
  logic [31:0] m_cap  [2][4];
  bit          m_vld  [2];
  logic [31:0] m_val  [2];
  int          m_src  [2];
  bit          m_tmo  [2];

  x_alp_exit_monitor #(.NUM_CH(4), .VALUE_W(32), .TIMEOUT_W(32), .WAIT_ALL(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr), .timeout_cycles_i(tmo),
    .ch_exit_valid_i(sv), .ch_exit_value_i(svals),
    .exit_valid_o(ev[0]), .exit_value_o(evl[0]), .exit_src_o(esrc[0]),
    .timeout_o(eto[0]), .done_mask_o(emask[0])
  );

  x_alp_exit_monitor #(.NUM_CH(4), .VALUE_W(32), .TIMEOUT_W(32), .WAIT_ALL(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr), .timeout_cycles_i(tmo),
    .ch_exit_valid_i(sv), .ch_exit_value_i(svals),
    .exit_valid_o(ev[1]), .exit_value_o(evl[1]), .exit_src_o(esrc[1]),
    .timeout_o(eto[1]), .done_mask_o(emask[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic mdl_clear(input int m);
    m_st[m]  = 0;
    m_cyc[m] = 0;
    for (int i = 0; i < 4; i++) begin
      m_mask[m][i] = 1'b0;
      m_cap[m][i]  = '0;
    end
    m_vld[m] = 1'b0;
    m_val[m] = '0;
    m_src[m] = 0;
    m_tmo[m] = 1'b0;
  endtask

  task automatic mdl_reset();
    mdl_clear(0);
    mdl_clear(1);
  endtask

  // One clock edge of the reference behaviour, using the inputs held at that edge
  task automatic mdl_edge();
    int first_new;
    int pick;
    bit all_done;
    bit complete;
    for (int m = 0; m < 2; m++) begin
      if (m_st[m] == 0) begin
        if (en) begin
          m_st[m]  = 1;
          m_cyc[m] = 0;
        end
      end else if (m_st[m] == 1) begin
        if (clr || !en) begin
          mdl_clear(m);
        end else begin
          m_cyc[m]++;
          first_new = -1;
          for (int i = 0; i < 4; i++) begin
            if (sv[i] && !m_mask[m][i]) begin
              m_mask[m][i] = 1'b1;
              m_cap[m][i]  = svals[i*32 +: 32];
              if (first_new < 0) first_new = i;
            end
          end
          all_done = 1'b1;
          for (int i = 0; i < 4; i++) if (!m_mask[m][i]) all_done = 1'b0;
          complete = (m == 1) ? all_done : (first_new >= 0);
          if (complete) begin
            m_st[m]  = 2;
            m_vld[m] = 1'b1;
            m_tmo[m] = 1'b0;
            if (m == 0) begin
              m_val[m] = m_cap[m][first_new];
              m_src[m] = first_new;
            end else begin
              pick = -1;
              for (int i = 0; i < 4; i++) if (pick < 0 && m_cap[m][i] != 0) pick = i;
              m_val[m] = (pick < 0) ? 32'h0 : m_cap[m][pick];
              m_src[m] = (pick < 0) ? 0 : pick;
            end
          end else if (tmo != 0 && m_cyc[m] >= longint'(tmo)) begin
            m_st[m]  = 2;
            m_vld[m] = 1'b1;
            m_tmo[m] = 1'b1;
            m_val[m] = 32'hFFFF_FFFF;
            m_src[m] = 0;
          end
        end
      end else begin
        if (clr) mdl_clear(m);
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] mk;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) mk[i] = m_mask[m][i];
      check_eq($sformatf("m%0d_valid", m), 64'(ev[m]), 64'(m_vld[m]));
      check_eq($sformatf("m%0d_value", m), 64'(evl[m]), 64'(m_val[m]));
      check_eq($sformatf("m%0d_src", m), 64'(esrc[m]), 64'(m_src[m]));
      check_eq($sformatf("m%0d_timeout", m), 64'(eto[m]), 64'(m_tmo[m]));
      check_eq($sformatf("m%0d_mask", m), 64'(emask[m]), 64'(mk));
    end
  endtask

  task automatic step();
    @(posedge clk);
    mdl_edge();
    #1;
    check_all();
  endtask

  task automatic strobe1(input int i, input logic [31:0] v);
    sv = '0;
    sv[i] = 1'b1;
    svals[i*32 +: 32] = v;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    mdl_reset();
    check_eq("rst_async_valid0", 64'(ev[0]), 64'd0);
    check_eq("rst_async_mask1", 64'(emask[1]), 64'd0);
    check_all();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; tmo = '0; sv = '0; svals = '0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk) rst = 1'b0;

    // First-exit with simultaneous strobes
    en = 1'b1;
    step();
    sv = 4'b0110;
    svals[2*32 +: 32] = 32'h5;
    svals[1*32 +: 32] = 32'h9;
    step();
    check_eq("tp1_valid", 64'(ev[0]), 64'd1);
    check_eq("tp1_value", 64'(evl[0]), 64'h9);
    check_eq("tp1_src", 64'(esrc[0]), 64'd1);
    check_eq("tp1_mask", 64'(emask[0]), 64'b0110);
    check_eq("tp1_timeout", 64'(eto[0]), 64'd0);
    sv = '0; clr = 1'b1;
    step();
    clr = 1'b0;
    step();

    // Wait-all selection with a duplicate strobe
    strobe1(0, 32'h0);  step();
    strobe1(3, 32'h2A); step();
    strobe1(1, 32'h7);  step();
    strobe1(0, 32'h99); step();
    check_eq("tp2_not_yet", 64'(ev[1]), 64'd0);
    strobe1(2, 32'h0);  step();
    sv = '0;
    check_eq("tp2_valid", 64'(ev[1]), 64'd1);
    check_eq("tp2_value", 64'(evl[1]), 64'h7);
    check_eq("tp2_src", 64'(esrc[1]), 64'd1);
    check_eq("tp2_mask", 64'(emask[1]), 64'hF);

    // Watchdog with T=10
    clr = 1'b1; step(); clr = 1'b0;
    tmo = 32'd10;
    step();
    repeat (9) step();
    check_eq("tp3_early", 64'(ev[0]), 64'd0);
    step();
    check_eq("tp3_valid", 64'(ev[0]), 64'd1);
    check_eq("tp3_timeout", 64'(eto[0]), 64'd1);
    check_eq("tp3_value", 64'(evl[0]), 64'hFFFF_FFFF);
    check_eq("tp3_src", 64'(esrc[0]), 64'd0);

    // Completion and watchdog in the same cycle
    clr = 1'b1; step(); clr = 1'b0;
    tmo = 32'd5;
    step();
    repeat (4) step();
    strobe1(0, 32'h3);
    step();
    sv = '0;
    check_eq("tp4_value", 64'(evl[0]), 64'h3);
    check_eq("tp4_timeout", 64'(eto[0]), 64'd0);
    check_eq("tp4_wait_all_timeout", 64'(eto[1]), 64'd1);

    // Lowered limit mid-run
    clr = 1'b1; step(); clr = 1'b0;
    tmo = 32'd20;
    step();
    repeat (8) step();
    tmo = 32'd3;
    step();
    check_eq("lowered_timeout", 64'(eto[1]), 64'd1);

    // Abort by dropping enable, then sticky DONE
    clr = 1'b1; step(); clr = 1'b0;
    tmo = '0;
    step();
    strobe1(1, 32'h55); step();
    sv = '0; en = 1'b0;
    step();
    check_eq("tp5_abort_valid", 64'(ev[1]), 64'd0);
    check_eq("tp5_abort_mask", 64'(emask[1]), 64'd0);
    en = 1'b1; clr = 1'b1; step(); clr = 1'b0;
    step();
    sv = 4'hF;
    svals = {32'h22, 32'h11, 32'h0, 32'h0};
    step();
    check_eq("tp5_value", 64'(evl[1]), 64'h11);
    check_eq("tp5_src", 64'(esrc[1]), 64'd2);
    for (int k = 0; k < 3; k++) begin
      sv = 4'(k + 5);
      svals = {$urandom, $urandom, $urandom, $urandom};
      en = 1'b0;
      tmo = 32'd1;
      step();
    end
    check_eq("tp5_sticky_value", 64'(evl[1]), 64'h11);
    check_eq("tp5_sticky_valid", 64'(ev[1]), 64'd1);
    sv = '0; clr = 1'b1; en = 1'b1; tmo = '0;
    step();
    clr = 1'b0;
    check_eq("tp5_clear_valid0", 64'(ev[0]), 64'd0);
    check_eq("tp5_clear_valid1", 64'(ev[1]), 64'd0);

    // Asynchronous reset with one instance in RUN and the other in DONE
    step();
    strobe1(0, 32'h5); step();
    sv = '0;
    async_reset();
    step();
    strobe1(3, 32'h44); step();
    sv = '0;
    check_eq("tp6_value", 64'(evl[0]), 64'h44);
    check_eq("tp6_src", 64'(esrc[0]), 64'd3);
    async_reset();

    // Randomised traffic
    for (int c = 0; c < 2500; c++) begin
      en = ($urandom_range(0, 99) < 96);
      if (m_st[0] == 2 || m_st[1] == 2) clr = ($urandom_range(0, 99) < 20);
      else clr = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 39) == 0) tmo = 32'($urandom_range(0, 30));
      for (int i = 0; i < 4; i++) begin
        sv[i] = ($urandom_range(0, 99) < 7);
        svals[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/x_alp_exit_monitor.md
# x_alp_exit_monitor

Parametrised exit aggregator for the X-ALP SoC: collects exit requests (valid plus code) from `NUM_CH` independent sources, such as cores, accelerators and testbench agents, and folds them into the single `exit_valid_o`/`exit_value_o` pair the simulation harness watches. It adds two behaviours the single-core exit path lacks:
- a first-exit or wait-for-all completion mode;
- a programmable watchdog timeout.

It sits between the per-subsystem exit registers and the SoC top-level exit ports.

## Interface
Parameters:
- `NUM_CH`, 4: number of exit sources, ≥1.
- `VALUE_W`, 32: exit code width.
- `TIMEOUT_W`, 32: watchdog counter width.
- `WAIT_ALL`, 0: 0 = finish on first channel exit; 1 = finish when every channel has exited.
- `TIMEOUT_CODE`, all ones (`VALUE_W` bits): code reported on watchdog expiry.
- `SRC_W`, `max(1,$clog2(NUM_CH))`: derived, not to be overridden.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `enable_i`, in, 1: arm the monitor; level.
- `clear_i`, in, 1: single-cycle pulse; abort or acknowledge and return to IDLE.
- `timeout_cycles_i`, in, `TIMEOUT_W`: watchdog limit in RUN cycles; 0 disables. Sampled every cycle.
- `ch_exit_valid_i`, in, `NUM_CH`: per-channel exit strobe; a pulse or a level is accepted.
- `ch_exit_value_i`, in, `NUM_CH`×`VALUE_W`: per-channel exit code, valid with its strobe.
- `exit_valid_o`, out, 1: aggregated exit; a level held until `clear_i`.
- `exit_value_o`, out, `VALUE_W`: aggregated exit code.
- `exit_src_o`, out, `SRC_W`: channel index that produced `exit_value_o`.
- `timeout_o`, out, 1: the exit was caused by the watchdog.
- `done_mask_o`, out, `NUM_CH`: channels captured in the current run.

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- **IDLE:**
  - Cycle counter, done mask and capture registers are held at 0.
  - `enable_i`=1 → RUN.
- **RUN:**
  - Each cycle, every channel with `ch_exit_valid_i[i]`=1 and `done_mask[i]`=0 latches `ch_exit_value_i[i]` and sets `done_mask[i]`.
  - Strobes from already-done channels are ignored; the first capture is final.
  - The cycle counter starts at 0 on RUN entry and increments every RUN cycle.
- **Completion with `WAIT_ALL`=0:**
  - Any capture → DONE.
  - `exit_value_o` and `exit_src_o` come from the lowest-index channel captured that cycle.
- **Completion with `WAIT_ALL`=1:**
  - The done mask including this cycle's captures is all ones → DONE.
  - `exit_value_o` is the captured value of the lowest-index channel whose value ≠ 0, and `exit_src_o` is that index.
  - If every captured value is 0: `exit_value_o`=0 and `exit_src_o`=0.
- **Timeout:**
  - Fires when `timeout_cycles_i`≠0, counter == `timeout_cycles_i`−1, and there is no completion this cycle → DONE.
  - Outputs: `timeout_o`=1, `exit_value_o`=`TIMEOUT_CODE`, `exit_src_o`=0.
- **Completion and timeout in the same cycle:** completion wins and `timeout_o`=0.
- **Lowered limit:** if `timeout_cycles_i` drops below counter+1 during RUN, the comparison is also satisfied when counter ≥ `timeout_cycles_i`−1, so timeout fires that cycle.
- **Counter saturation:** the counter saturates at all ones and never wraps.
- **RUN with `enable_i`=0:** → IDLE, all capture state cleared, no exit reported.
- **DONE:**
  - Outputs are frozen.
  - `ch_exit_valid_i`, `enable_i` and `timeout_cycles_i` are ignored.
  - `clear_i` → IDLE.
- **`clear_i` in RUN:** → IDLE (abort).
- **`clear_i` in IDLE:** no effect.
- **`clear_i` together with a completion in RUN:** `clear_i` wins and no exit is reported.
- **`done_mask_o`:** remains valid in DONE and reflects all captures up to and including the completing cycle.

## Timing
- All outputs are registered.
- Reset values: `exit_valid_o`=0, `exit_value_o`=0, `exit_src_o`=0, `timeout_o`=0, `done_mask_o`=0.
- IDLE→RUN: the edge at which `enable_i`=1 is sampled. The first RUN cycle follows that edge.
- Exit latency: a strobe sampled at edge N raises `exit_valid_o` (plus value, source and mask) immediately after edge N, i.e. 1 cycle from strobe to output.
- Timeout: with limit T, RUN lasts exactly T cycles. `exit_valid_o` and `timeout_o` rise after the T-th RUN edge.
- `clear_i` sampled at edge N: all outputs return to 0 after edge N. If `enable_i` is still 1, RUN is re-entered after edge N+1.
- `rst_i` asserted in any state: asynchronous return to IDLE with reset values. Deassertion is synchronised externally.

## Test plan
- **First-exit, simultaneous strobes.** `WAIT_ALL`=0, `NUM_CH`=4, T=0. Enable, then on the same cycle strobe ch2=0x5 and ch1=0x9. Required, one cycle later: `exit_valid_o`=1, `exit_value_o`=0x9, `exit_src_o`=1, `done_mask_o`=0b0110, `timeout_o`=0.
- **Wait-all, selection and duplicate strobes.** `WAIT_ALL`=1. Strobe ch0=0, ch3=0x2A, ch1=0x7 and ch2=0 on separate cycles, and re-strobe ch0=0x99 before the last one. Required: `exit_valid_o` rises only after ch2; value 0x7, source 1, mask 0b1111 (the re-strobe is ignored).
- **Timeout.** T=10, no strobes. Required: `exit_valid_o` and `timeout_o` rise after exactly 10 RUN cycles, `exit_value_o`=0xFFFFFFFF, `exit_src_o`=0.
- **Completion versus timeout.** T=5, strobe ch0=0x3 in the 5th RUN cycle. Required: `exit_value_o`=0x3, `timeout_o`=0.
- **Abort and sticky DONE.**
  - Drop `enable_i` mid-RUN after ch1 is captured: all outputs stay 0 and the FSM returns to IDLE.
  - Re-enable and complete the run; then in DONE, strobe other channels and drop `enable_i`: outputs must be unchanged.
  - Pulse `clear_i`: all outputs become 0 the next cycle.
- **Asynchronous reset.** Assert `rst_i` mid-RUN and while in DONE, off the clock edge. Required: outputs go to 0 without waiting for a clock edge; after release and with `enable_i` high, a fresh run behaves normally.
